// File: rtl/data_mem_stage_pkg.sv
// Shared pipeline definitions: memory access encodings and data memory depth.
// The load extender downstream decodes load_op with the same encoding.
package data_mem_stage_pkg;

    localparam int DEPTH_WORDS_DEFAULT = 4096;

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_SW   = 2'd1,
        ST_SH   = 2'd2,
        ST_SB   = 2'd3
    } store_op_t;

    typedef enum logic [1:0] {
        LD_NONE = 2'd0,
        LD_LW   = 2'd1,
        LD_LH   = 2'd2,
        LD_LB   = 2'd3
    } load_op_t;

    // Loads and stores share the width encoding (1 word, 2 half, 3 byte),
    // so one alignment rule serves both.
    function automatic logic width_misaligned(input logic [1:0] op, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (op)
            2'd1:    bad = (addr_lo != 2'b00);
            2'd2:    bad = addr_lo[0];
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_mem_stage_store_align.sv
// Store alignment: byte enables and lane-replicated write data for sw/sh/sb.
// Alignment and range gating are applied by the caller.
module store_align
    import data_mem_stage_pkg::*;
(
    input  store_op_t   store_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  byteen_raw,
    output logic [31:0] wdata_aligned
);

    // Select the lanes touched by the store and replicate the source data so
    // every enabled lane already holds the correct byte.
    always_comb begin
        byteen_raw    = 4'b0000;
        wdata_aligned = wdata;
        case (store_op)
            ST_SW: begin
                byteen_raw    = 4'b1111;
                wdata_aligned = wdata;
            end
            ST_SH: begin
                byteen_raw    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_aligned = {2{wdata[15:0]}};
            end
            ST_SB: begin
                byteen_raw    = 4'b0001 << addr_lo;
                wdata_aligned = {4{wdata[7:0]}};
            end
            default: begin
                byteen_raw    = 4'b0000;
                wdata_aligned = wdata;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_stage.sv
// M-stage data memory with byte-lane writes, combinational read and the
// M/W pipeline register. Memory is held as four byte-lane arrays so each lane
// is written by exactly one process.
module data_mem_stage
    import data_mem_stage_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  store_op,
    input  logic [1:0]  load_op,
    input  logic [31:0] pc,
    output logic [3:0]  byteen,
    output logic        misalign,
    output logic [31:0] rdata_w,
    output logic [15:0] addr_w,
    output logic [1:0]  load_op_w,
    output logic [31:0] pc_w
);

    localparam int          IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);

    logic [3:0]       byteen_raw;
    logic [31:0]      wdata_aligned;
    logic             store_mis;
    logic             load_mis;
    logic             in_range;
    logic [IDX_W-1:0] word_idx;
    logic [3:0][7:0]  lane_rd;
    logic [31:0]      rd_word;

    store_align u_store_align (
        .store_op      (store_op_t'(store_op)),
        .addr_lo       (addr[1:0]),
        .wdata         (wdata),
        .byteen_raw    (byteen_raw),
        .wdata_aligned (wdata_aligned)
    );

    assign store_mis = width_misaligned(store_op, addr[1:0]);
    assign load_mis  = width_misaligned(load_op, addr[1:0]);
    assign misalign  = store_mis | load_mis;
    assign in_range  = (addr[31:2] < DEPTH_LIMIT);
    assign word_idx  = addr[IDX_W+1:2];

    // Faulting or out-of-range accesses must never reach the array.
    assign byteen = (misalign || !in_range) ? 4'b0000 : byteen_raw;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];

            // Byte lane storage: full clear on reset, otherwise write when enabled.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int i = 0; i < DEPTH_WORDS; i++) begin
                        lane_mem[IDX_W'(i)] <= 8'h00;
                    end
                end else if (en && byteen[gi]) begin
                    lane_mem[word_idx] <= wdata_aligned[gi*8 +: 8];
                end
            end

            assign lane_rd[gi] = lane_mem[word_idx];
        end
    endgenerate

    // Reads see the pre-write contents; out-of-range words read as zero.
    assign rd_word = in_range ? lane_rd : 32'h0000_0000;

    // M/W register: clear on reset, hold on stall, zero on flush.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_w   <= '0;
            addr_w    <= '0;
            load_op_w <= '0;
            pc_w      <= '0;
        end else if (en) begin
            if (flush) begin
                rdata_w   <= '0;
                addr_w    <= '0;
                load_op_w <= '0;
                pc_w      <= '0;
            end else begin
                rdata_w   <= rd_word;
                addr_w    <= addr[15:0];
                // A store wins over a simultaneous load; a faulting load is dropped.
                load_op_w <= (store_op != ST_NONE || load_mis) ? LD_NONE : load_op;
                pc_w      <= pc;
            end
        end
    end

endmodule
